tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux.sv | 143 ++++++++++++++
 tb/tb_tdm_demux.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// TDM demultiplexer: routes a slot-multiplexed word stream into per-channel
// holding registers, tracking frame alignment through in_sof.
module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    input  logic                         in_sof,
    output logic                         in_ready,
    output logic [CHANNELS*WIDTH-1:0]    ch_data,
    output logic [CHANNELS-1:0]          ch_valid,
    input  logic [CHANNELS-1:0]          ch_ack,
    output logic [$clog2(CHANNELS)-1:0]  slot,
    output logic [7:0]                   frame_cnt,
    output logic                         sync_err
);

    localparam int SW = $clog2(CHANNELS);
    localparam logic [SW-1:0] SLOT_FIRST = SW'(0);
    localparam logic [SW-1:0] SLOT_NEXT  = SW'(1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(CHANNELS - 1);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]                  state_r;
    logic [SW-1:0]               slot_r;
    logic [7:0]                  frame_r;
    logic                        err_r;
    logic [CHANNELS-1:0]         valid_r;
    logic [CHANNELS*WIDTH-1:0]   data_r;

    logic                        ready_s;
    logic                        xfer_s;
    logic [0:0]                  state_n_s;
    logic [SW-1:0]               slot_n_s;
    logic [7:0]                  frame_n_s;
    logic                        err_n_s;
    logic                        wr_en_s;
    logic [SW-1:0]               wr_idx_s;

    // Space available in the addressed channel, or it is being drained this cycle.
    always_comb begin
        ready_s = ~valid_r[slot_r] | ch_ack[slot_r];
        xfer_s  = in_valid & ready_s;
    end

    // Framing state machine: decides where (and whether) an accepted word lands.
    always_comb begin
        state_n_s = state_r;
        slot_n_s  = slot_r;
        frame_n_s = frame_r;
        err_n_s   = 1'b0;
        wr_en_s   = 1'b0;
        wr_idx_s  = slot_r;
        if (xfer_s) begin
            case (state_r)
                ST_HUNT: begin
                    if (in_sof) begin
                        wr_en_s   = 1'b1;
                        wr_idx_s  = SLOT_FIRST;
                        slot_n_s  = SLOT_NEXT;
                        state_n_s = ST_LOCKED;
                    end else begin
                        state_n_s = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (in_sof && (slot_r != SLOT_FIRST)) begin
                        // Early SOF: realign on this word, partial frame is abandoned.
                        err_n_s  = 1'b1;
                        wr_en_s  = 1'b1;
                        wr_idx_s = SLOT_FIRST;
                        slot_n_s = SLOT_NEXT;
                    end else if (!in_sof && (slot_r == SLOT_FIRST)) begin
                        err_n_s   = 1'b1;
                        state_n_s = ST_HUNT;
                    end else begin
                        wr_en_s  = 1'b1;
                        wr_idx_s = slot_r;
                        slot_n_s = slot_r + SLOT_NEXT;
                        if (slot_r == SLOT_LAST) begin
                            frame_n_s = frame_r + 8'd1;
                        end else begin
                            frame_n_s = frame_r;
                        end
                    end
                end
                default: begin
                    state_n_s = ST_HUNT;
                    slot_n_s  = SLOT_FIRST;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // Control registers: state, slot pointer, frame counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HUNT;
            slot_r  <= SLOT_FIRST;
            frame_r <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            slot_r  <= slot_n_s;
            frame_r <= frame_n_s;
            err_r   <= err_n_s;
        end
    end

    // Channel holding registers: a write wins over a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {CHANNELS{1'b0}};
            data_r  <= {(CHANNELS*WIDTH){1'b0}};
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_en_s && (wr_idx_s == SW'(k))) begin
                    valid_r[k]                <= 1'b1;
                    data_r[k*WIDTH +: WIDTH]  <= in_data;
                end else if (ch_ack[k]) begin
                    valid_r[k] <= 1'b0;
                end else begin
                    valid_r[k] <= valid_r[k];
                end
            end
        end
    end

    assign in_ready  = ready_s;
    assign ch_data   = data_r;
    assign ch_valid  = valid_r;
    assign slot      = slot_r;
    assign frame_cnt = frame_r;
    assign sync_err  = err_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed, table-driven bench for tdm_demux (WIDTH=8, CHANNELS=4) with a
// hand-written frame-counter wrap sequence.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ack;
    logic [1:0]  slot;
    logic [7:0]  frame_cnt;
    logic        sync_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        v;
        logic        sof;
        logic [7:0]  d;
        logic [3:0]  ack;
        logic        rdy;
        logic [31:0] e_data;
        logic [3:0]  e_valid;
        logic [1:0]  e_slot;
        logic [7:0]  e_frame;
        logic        e_err;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .ch_ack    (ch_ack),
        .slot      (slot),
        .frame_cnt (frame_cnt),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic s, input logic [7:0] d,
                                input logic [3:0] a, input logic rdy, input logic [31:0] ed,
                                input logic [3:0] ev, input logic [1:0] es, input logic [7:0] ef,
                                input logic ee);
        vec_t t;
        t.rst = r; t.v = v; t.sof = s; t.d = d; t.ack = a; t.rdy = rdy;
        t.e_data = ed; t.e_valid = ev; t.e_slot = es; t.e_frame = ef; t.e_err = ee;
        return t;
    endfunction

    initial begin
        logic err_seen;
        //              rst   v     sof   data   ack      rdy   ch_data        valid    slot  frame  err
        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 8'h11, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 2'd0, 8'd0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 8'hAA, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 2'd0, 8'd0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 8'hBB, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 2'd0, 8'd0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b1, 8'h01, 4'b0000, 1'b1, 32'h00000001, 4'b0001, 2'd1, 8'd0, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 2'd0, 8'd0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b1, 8'h11, 4'b0000, 1'b1, 32'h00000011, 4'b0001, 2'd1, 8'd0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 8'hFF, 4'b0000, 1'b1, 32'h00000011, 4'b0001, 2'd1, 8'd0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 8'h22, 4'b0000, 1'b1, 32'h00002211, 4'b0011, 2'd2, 8'd0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 8'h33, 4'b0000, 1'b1, 32'h00332211, 4'b0111, 2'd3, 8'd0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 8'h44, 4'b0000, 1'b1, 32'h44332211, 4'b1111, 2'd0, 8'd1, 1'b0);
        // Backpressure until channel 0 is acked, then accept in the ack cycle
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 8'h55, 4'b0000, 1'b0, 32'h44332211, 4'b1111, 2'd0, 8'd1, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 8'h55, 4'b0000, 1'b0, 32'h44332211, 4'b1111, 2'd0, 8'd1, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 8'h55, 4'b0001, 1'b1, 32'h44332255, 4'b1111, 2'd1, 8'd1, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 8'h00, 4'b0010, 1'b1, 32'h44332255, 4'b1101, 2'd1, 8'd1, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 4'b1100, 1'b1, 32'h44332255, 4'b0001, 2'd1, 8'd1, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 8'h00, 4'b0010, 1'b1, 32'h44332255, 4'b0001, 2'd1, 8'd1, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 8'h66, 4'b0000, 1'b1, 32'h44336655, 4'b0011, 2'd2, 8'd1, 1'b0);
        // Early SOF at slot 2
        vecs[17] = mk(1'b0, 1'b1, 1'b1, 8'h77, 4'b0000, 1'b1, 32'h44336677, 4'b0011, 2'd1, 8'd1, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 32'h44336677, 4'b0011, 2'd1, 8'd1, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 1'b0, 8'h88, 4'b0010, 1'b1, 32'h44338877, 4'b0011, 2'd2, 8'd1, 1'b0);
        vecs[20] = mk(1'b0, 1'b1, 1'b0, 8'h9A, 4'b0000, 1'b1, 32'h449A8877, 4'b0111, 2'd3, 8'd1, 1'b0);
        vecs[21] = mk(1'b0, 1'b1, 1'b0, 8'hBC, 4'b0000, 1'b1, 32'hBC9A8877, 4'b1111, 2'd0, 8'd2, 1'b0);
        // Missing SOF at slot 0: discard, HUNT; the ack still drains channel 0
        vecs[22] = mk(1'b0, 1'b1, 1'b0, 8'h99, 4'b0001, 1'b1, 32'hBC9A8877, 4'b1110, 2'd0, 8'd2, 1'b1);
        vecs[23] = mk(1'b0, 1'b1, 1'b0, 8'hDD, 4'b0000, 1'b1, 32'hBC9A8877, 4'b1110, 2'd0, 8'd2, 1'b0);
        vecs[24] = mk(1'b0, 1'b1, 1'b1, 8'hE1, 4'b0000, 1'b1, 32'hBC9A88E1, 4'b1111, 2'd1, 8'd2, 1'b0);
        vecs[25] = mk(1'b0, 1'b1, 1'b0, 8'hE2, 4'b0010, 1'b1, 32'hBC9AE2E1, 4'b1111, 2'd2, 8'd2, 1'b0);
        vecs[26] = mk(1'b0, 1'b1, 1'b0, 8'hE3, 4'b0100, 1'b1, 32'hBCE3E2E1, 4'b1111, 2'd3, 8'd2, 1'b0);
        // Reset mid-frame, then non-SOF words are discarded
        vecs[27] = mk(1'b1, 1'b1, 1'b0, 8'hF0, 4'b1000, 1'b1, 32'h00000000, 4'b0000, 2'd0, 8'd0, 1'b0);
        vecs[28] = mk(1'b0, 1'b1, 1'b0, 8'hF1, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 2'd0, 8'd0, 1'b0);
        vecs[29] = mk(1'b0, 1'b1, 1'b0, 8'hF2, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 2'd0, 8'd0, 1'b0);

        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; ch_ack = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_ch_valid", -1, {28'd0, ch_valid}, 32'd0);
        chk("reset_frame_cnt", -1, {24'd0, frame_cnt}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; in_valid = vecs[i].v; in_sof = vecs[i].sof;
            in_data = vecs[i].d; ch_ack = vecs[i].ack;
            #1;
            if (vecs[i].v) chk("in_ready", i, {31'd0, in_ready}, {31'd0, vecs[i].rdy});
            @(posedge clk); #1;
            chk("ch_data", i, ch_data, vecs[i].e_data);
            chk("ch_valid", i, {28'd0, ch_valid}, {28'd0, vecs[i].e_valid});
            chk("slot", i, {30'd0, slot}, {30'd0, vecs[i].e_slot});
            chk("frame_cnt", i, {24'd0, frame_cnt}, {24'd0, vecs[i].e_frame});
            chk("sync_err", i, {31'd0, sync_err}, {31'd0, vecs[i].e_err});
        end

        // 256 complete frames with channels drained every cycle: frame_cnt wraps to 0
        rst = 1'b1; in_valid = 1'b0; ch_ack = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        err_seen = 1'b0;
        for (int f = 0; f < 256; f++) begin
            if (f == 255) chk("frame_cnt_255", f, {24'd0, frame_cnt}, 32'd255);
            for (int s = 0; s < 4; s++) begin
                in_valid = 1'b1; in_sof = (s == 0); ch_ack = 4'b1111;
                in_data = 8'(f + s);
                @(posedge clk); #1;
                err_seen = err_seen | sync_err;
            end
        end
        in_valid = 1'b0; ch_ack = 4'b0000;
        chk("frame_cnt_wrap", 256, {24'd0, frame_cnt}, 32'd0);
        chk("slot_after_wrap", 256, {30'd0, slot}, 32'd0);
        chk("no_sync_err_clean", 256, {31'd0, err_seen}, 32'd0);
        chk("last_word_ch3", 256, {24'd0, ch_data[31:24]}, {24'd0, 8'(255 + 3)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
